// File: rtl/tlb_pkg.sv
// Shared encodings for the TLB-maintenance sequencer: op codes, INVTLB op codes,
// controller states and field widths.
package tlb_pkg;

  localparam int ASID_W = 10;
  localparam int VPN_W  = 19;

  typedef enum logic [2:0] {
    TLB_OP_SRCH = 3'd0,
    TLB_OP_RD   = 3'd1,
    TLB_OP_WR   = 3'd2,
    TLB_OP_FILL = 3'd3,
    TLB_OP_INV  = 3'd4
  } tlb_op_e;

  typedef enum logic [4:0] {
    INV_ALL0        = 5'd0,
    INV_ALL1        = 5'd1,
    INV_G1          = 5'd2,
    INV_G0          = 5'd3,
    INV_G0_ASID     = 5'd4,
    INV_G0_ASID_VPN = 5'd5,
    INV_GASID_VPN   = 5'd6
  } tlb_inv_op_e;

  localparam logic [4:0] INV_OP_MAX = 5'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRCH,
    S_RD,
    S_WR,
    S_INV,
    S_DONE
  } tlb_state_e;

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB predicate for one entry: asserts hit when the entry is
// valid and selected by the invalidate op and request ASID/VPN.
module tlb_inv_match
  import tlb_pkg::*;
(
  input  logic [4:0]        inv_op,
  input  logic              g,
  input  logic              e,
  input  logic [ASID_W-1:0] asid,
  input  logic [VPN_W-1:0]  vpn,
  input  logic [ASID_W-1:0] req_asid,
  input  logic [VPN_W-1:0]  req_vpn,
  output logic              hit
);

  logic asid_eq;
  logic vpn_eq;
  logic sel;

  assign asid_eq = (asid == req_asid);
  assign vpn_eq  = (vpn == req_vpn);

  always_comb begin
    sel = 1'b0;
    case (inv_op)
      INV_ALL0, INV_ALL1: sel = 1'b1;
      INV_G1:             sel = g;
      INV_G0:             sel = ~g;
      INV_G0_ASID:        sel = ~g & asid_eq;
      INV_G0_ASID_VPN:    sel = ~g & asid_eq & vpn_eq;
      INV_GASID_VPN:      sel = (g | asid_eq) & vpn_eq;
      default:            sel = 1'b0;
    endcase
    hit = sel & e;
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Commit-side sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB.
// Define TLBFILL_LFSR_EN to take the fill index from a free-running LFSR.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_inv_op,
  input  logic [ASID_W-1:0] req_inv_asid,
  input  logic [VPN_W-1:0]  req_inv_va,
  input  logic [IDX_W-1:0]  csr_idx,
  output logic [IDX_W-1:0]  tlb_ridx,
  input  logic              tlb_r_e,
  input  logic              tlb_r_g,
  input  logic [ASID_W-1:0] tlb_r_asid,
  input  logic [VPN_W-1:0]  tlb_r_vpn,
  input  logic              tlb_s_hit,
  input  logic [IDX_W-1:0]  tlb_s_idx,
  output logic              tlb_we,
  output logic [IDX_W-1:0]  tlb_widx,
  output logic              tlb_inv_we,
  output logic [IDX_W-1:0]  tlb_inv_idx,
  output logic              csr_srch_we,
  output logic              csr_rd_we,
  output logic              csr_ne,
  output logic [IDX_W-1:0]  csr_idx_o,
  output logic              resp_valid,
  output logic              resp_ex
);

  tlb_state_e        state_q, state_n;
  tlb_op_e           op_q;
  logic [4:0]        inv_op_q;
  logic [ASID_W-1:0] asid_q;
  logic [VPN_W-1:0]  va_q;
  logic              ex_q;
  logic              dly_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  fill_idx;
  logic              accept;
  logic              nop_op;
  logic              inv_hit;

  assign accept = (state_q == S_IDLE) & req_valid & ~flush;
  // Ops with no array work still answer at T+2, so DONE idles one cycle first.
  assign nop_op = (req_op > TLB_OP_INV) |
                  ((req_op == TLB_OP_INV) & (req_inv_op > INV_OP_MAX));

  tlb_inv_match u_match (
    .inv_op   (inv_op_q),
    .g        (tlb_r_g),
    .e        (tlb_r_e),
    .asid     (tlb_r_asid),
    .vpn      (tlb_r_vpn),
    .req_asid (asid_q),
    .req_vpn  (va_q),
    .hit      (inv_hit)
  );

  always_comb begin
    state_n     = state_q;
    req_ready   = 1'b0;
    tlb_ridx    = '0;
    tlb_we      = 1'b0;
    tlb_widx    = '0;
    tlb_inv_we  = 1'b0;
    tlb_inv_idx = '0;
    csr_srch_we = 1'b0;
    csr_rd_we   = 1'b0;
    csr_ne      = 1'b0;
    csr_idx_o   = '0;
    resp_valid  = 1'b0;
    resp_ex     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          case (tlb_op_e'(req_op))
            TLB_OP_SRCH:             state_n = S_SRCH;
            TLB_OP_RD:               state_n = S_RD;
            TLB_OP_WR, TLB_OP_FILL:  state_n = S_WR;
            TLB_OP_INV:              state_n = nop_op ? S_DONE : S_INV;
            default:                 state_n = S_DONE;
          endcase
        end
      end
      S_SRCH: begin
        csr_srch_we = ~flush;
        csr_ne      = ~flush & ~tlb_s_hit;
        csr_idx_o   = (~flush & tlb_s_hit) ? tlb_s_idx : '0;
        state_n     = S_DONE;
      end
      S_RD: begin
        tlb_ridx  = csr_idx;
        csr_rd_we = ~flush;
        csr_ne    = ~flush & ~tlb_r_e;
        state_n   = S_DONE;
      end
      S_WR: begin
        tlb_we   = ~flush;
        tlb_widx = (op_q == TLB_OP_FILL) ? fill_idx : csr_idx;
        state_n  = S_DONE;
      end
      S_INV: begin
        tlb_ridx    = ptr_q;
        tlb_inv_idx = ptr_q;
        tlb_inv_we  = inv_hit & ~flush;
        if (ptr_q == IDX_W'(ENTRIES - 1)) state_n = S_DONE;
      end
      S_DONE: begin
        if (!dly_q) begin
          resp_valid = ~flush;
          resp_ex    = ~flush & ex_q;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= TLB_OP_SRCH;
      inv_op_q <= '0;
      asid_q   <= '0;
      va_q     <= '0;
      ex_q     <= 1'b0;
      dly_q    <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q <= state_n;
      dly_q   <= accept & nop_op;
      ptr_q   <= (state_q == S_INV && !flush) ? ptr_q + 1'b1 : '0;
      if (accept) begin
        op_q     <= tlb_op_e'(req_op);
        inv_op_q <= req_inv_op;
        asid_q   <= req_inv_asid;
        va_q     <= req_inv_va;
        ex_q     <= (req_op == TLB_OP_INV) & (req_inv_op > INV_OP_MAX);
      end
    end
  end

`ifdef TLBFILL_LFSR_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'h01;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign fill_idx = lfsr_q[IDX_W-1:0];
`else
  logic [IDX_W-1:0] fill_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fill_cnt_q <= '0;
    else if (state_q == S_WR && op_q == TLB_OP_FILL && !flush)
      fill_cnt_q <= fill_cnt_q + 1'b1;
  end

  assign fill_idx = fill_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl (default build): a table of single-cycle
// ops plus fill, INVTLB-walk and flush sequences, checked through a scoreboard.
module tb_tlb_op_ctrl;
  import tlb_pkg::*;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_inv_op;
  logic [ASID_W-1:0] req_inv_asid;
  logic [VPN_W-1:0]  req_inv_va;
  logic [IDX_W-1:0]  csr_idx;
  logic [IDX_W-1:0]  tlb_ridx;
  logic              tlb_r_e, tlb_r_g;
  logic [ASID_W-1:0] tlb_r_asid;
  logic [VPN_W-1:0]  tlb_r_vpn;
  logic              tlb_s_hit;
  logic [IDX_W-1:0]  tlb_s_idx;
  logic              tlb_we;
  logic [IDX_W-1:0]  tlb_widx;
  logic              tlb_inv_we;
  logic [IDX_W-1:0]  tlb_inv_idx;
  logic              csr_srch_we, csr_rd_we, csr_ne;
  logic [IDX_W-1:0]  csr_idx_o;
  logic              resp_valid, resp_ex;

  // Behavioural entry array answering the controller's read port.
  logic              e_arr[ENTRIES];
  logic              g_arr[ENTRIES];
  logic [ASID_W-1:0] asid_arr[ENTRIES];
  logic [VPN_W-1:0]  vpn_arr[ENTRIES];

  assign tlb_r_e    = e_arr[tlb_ridx];
  assign tlb_r_g    = g_arr[tlb_ridx];
  assign tlb_r_asid = asid_arr[tlb_ridx];
  assign tlb_r_vpn  = vpn_arr[tlb_ridx];

  tlb_op_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_va(req_inv_va),
    .csr_idx(csr_idx), .tlb_ridx(tlb_ridx),
    .tlb_r_e(tlb_r_e), .tlb_r_g(tlb_r_g), .tlb_r_asid(tlb_r_asid), .tlb_r_vpn(tlb_r_vpn),
    .tlb_s_hit(tlb_s_hit), .tlb_s_idx(tlb_s_idx),
    .tlb_we(tlb_we), .tlb_widx(tlb_widx),
    .tlb_inv_we(tlb_inv_we), .tlb_inv_idx(tlb_inv_idx),
    .csr_srch_we(csr_srch_we), .csr_rd_we(csr_rd_we), .csr_ne(csr_ne),
    .csr_idx_o(csr_idx_o), .resp_valid(resp_valid), .resp_ex(resp_ex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [30:0] mk(input logic we, inv, srch, rd, rv, ex, ne,
                                     input logic [5:0] widx, iidx, idxo, ridx);
    return {we, inv, srch, rd, rv, ex, ne, widx, iidx, idxo, ridx};
  endfunction

  logic [30:0] obs;
  assign obs = mk(tlb_we, tlb_inv_we, csr_srch_we, csr_rd_we, resp_valid, resp_ex,
                  csr_ne, tlb_widx, tlb_inv_idx, csr_idx_o, tlb_ridx);

  typedef struct {
    int          cyc;
    logic [30:0] sig;
    string       name;
  } exp_t;
  exp_t q[$];

  function automatic void push(input int c, input logic [30:0] s, input string nm);
    exp_t x;
    x.cyc = c; x.sig = s; x.name = nm;
    q.push_back(x);
  endfunction

  // Any strobe cycle must match the oldest expected event, cycle-exact.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && (tlb_we | tlb_inv_we | csr_srch_we | csr_rd_we | resp_valid)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: cyc %0d sig %h, none expected", cyc, obs);
      end else begin
        x = q.pop_front();
        if (x.cyc != cyc || x.sig !== obs) begin
          n_err++;
          $display("FAIL %s: got cyc %0d sig %h, want cyc %0d sig %h",
                   x.name, cyc, obs, x.cyc, x.sig);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] iop,
                       input logic [9:0] asid, input logic [18:0] va,
                       input logic [5:0] cidx, output int t);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_inv_op = iop;
    req_inv_asid = asid; req_inv_va = va; csr_idx = cidx;
    t = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: %0d events outstanding, want 0", nm, q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic init_array();
    for (int p = 0; p < ENTRIES; p++) begin
      e_arr[p] = 1'b1; g_arr[p] = 1'b0;
      asid_arr[p] = 10'h100 + 10'(p); vpn_arr[p] = '0;
    end
    asid_arr[2]  = 10'h3; vpn_arr[2]  = 19'h1234;
    asid_arr[40] = 10'h3; vpn_arr[40] = 19'h1234;
    g_arr[7] = 1'b1; asid_arr[7] = 10'h3; vpn_arr[7] = 19'h1234;
    asid_arr[10] = 10'h3; vpn_arr[10] = 19'h1235;
    asid_arr[11] = 10'h3; vpn_arr[11] = 19'h1234; e_arr[11] = 1'b0;
    e_arr[20] = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [4:0]  iop;
    logic [5:0]  cidx;
    logic        s_hit;
    logic [5:0]  s_idx;
    logic        re;
    logic        has1;
    logic [30:0] sig1;
    logic        ex;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int t;
    logic [30:0] rsp_ok;
    rsp_ok = mk(0, 0, 0, 0, 1, 0, 0, 6'd0, 6'd0, 6'd0, 6'd0);

    tbl[0] = '{"srch_hit",  3'd0, 5'd0, 6'd0,  1'b1, 6'd13, 1'b0, 1'b1, mk(0,0,1,0,0,0,0, 6'd0,  6'd0, 6'd13, 6'd0), 1'b0};
    tbl[1] = '{"srch_miss", 3'd0, 5'd0, 6'd0,  1'b0, 6'd9,  1'b0, 1'b1, mk(0,0,1,0,0,0,1, 6'd0,  6'd0, 6'd0,  6'd0), 1'b0};
    tbl[2] = '{"rd_e0",     3'd1, 5'd0, 6'd5,  1'b0, 6'd0,  1'b0, 1'b1, mk(0,0,0,1,0,0,1, 6'd0,  6'd0, 6'd0,  6'd5), 1'b0};
    tbl[3] = '{"rd_e1",     3'd1, 5'd0, 6'd5,  1'b0, 6'd0,  1'b1, 1'b1, mk(0,0,0,1,0,0,0, 6'd0,  6'd0, 6'd0,  6'd5), 1'b0};
    tbl[4] = '{"wr",        3'd2, 5'd0, 6'd33, 1'b0, 6'd0,  1'b1, 1'b1, mk(1,0,0,0,0,0,0, 6'd33, 6'd0, 6'd0,  6'd0), 1'b0};
    tbl[5] = '{"inv_op9",   3'd4, 5'd9, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 31'd0, 1'b1};
    tbl[6] = '{"inv_op7",   3'd4, 5'd7, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 31'd0, 1'b1};
    tbl[7] = '{"rsv_op5",   3'd5, 5'd0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 31'd0, 1'b0};
    tbl[8] = '{"rsv_op7",   3'd7, 5'd0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 31'd0, 1'b0};

    init_array();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_inv_op = '0;
    req_inv_asid = '0; req_inv_va = '0; csr_idx = '0; tlb_s_hit = 1'b0; tlb_s_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_outputs", 32'(obs), 32'd0);
    rst_n = 1'b1;

    // Sequential fill counter from reset, including the wrap back to 0.
    for (int i = 0; i < 65; i++) begin
      issue(3'd3, 5'd0, 10'd0, 19'd0, 6'd17, t);
      push(t + 1, mk(1, 0, 0, 0, 0, 0, 0, 6'(i % 64), 6'd0, 6'd0, 6'd0), "fill_widx");
      push(t + 2, rsp_ok, "fill_resp");
      drain("fill");
    end

    foreach (tbl[i]) begin
      e_arr[5] = tbl[i].re; tlb_s_hit = tbl[i].s_hit; tlb_s_idx = tbl[i].s_idx;
      issue(tbl[i].op, tbl[i].iop, 10'd0, 19'd0, tbl[i].cidx, t);
      if (tbl[i].has1) push(t + 1, tbl[i].sig1, tbl[i].name);
      push(t + 2, mk(0, 0, 0, 0, 1, tbl[i].ex, 0, 6'd0, 6'd0, 6'd0, 6'd0), tbl[i].name);
      drain(tbl[i].name);
    end
    tlb_s_hit = 1'b0;

    // INVTLB op 5: only the non-global ASID 3 / VPN 0x1234 valid entries go.
    init_array();
    issue(3'd4, 5'd5, 10'h3, 19'h1234, 6'd0, t);
    chk("inv_busy_ready", 32'(req_ready), 32'd0);
    push(t + 3,  mk(0, 1, 0, 0, 0, 0, 0, 6'd0, 6'd2,  6'd0, 6'd2),  "inv5_p2");
    push(t + 41, mk(0, 1, 0, 0, 0, 0, 0, 6'd0, 6'd40, 6'd0, 6'd40), "inv5_p40");
    push(t + 65, rsp_ok, "inv5_resp");
    drain("inv5");

    // Flush an invalidate-all walk at p=20, then a G=1 walk must start at p=0.
    issue(3'd4, 5'd0, 10'h0, 19'h0, 6'd0, t);
    for (int p = 0; p < 20; p++)
      if (e_arr[p]) push(t + 1 + p, mk(0, 1, 0, 0, 0, 0, 0, 6'd0, 6'(p), 6'd0, 6'(p)), "inv0_walk");
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_ready", 32'(req_ready), 32'd1);
    chk("flush_pending", 32'(q.size()), 32'd0);
    repeat (70) @(posedge clk);
    issue(3'd4, 5'd2, 10'h0, 19'h0, 6'd0, t);
    push(t + 8,  mk(0, 1, 0, 0, 0, 0, 0, 6'd0, 6'd7, 6'd0, 6'd7), "inv2_p7");
    push(t + 65, rsp_ok, "inv2_resp");
    drain("inv2");
    chk("final_ready", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
